board_io_frontend: RTL

BOARD_IO_FRONTEND -- requirements
Module: board_io_frontend

---
 rtl/board_io_pkg.sv | 20 ++
 rtl/io_debounce.sv | 52 +++++
 rtl/board_io_frontend.sv | 115 +++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - default parameters and counter width helper for the board I/O frontend
package board_io_pkg;

    localparam int SW_NUM_DEF       = 8;
    localparam int BTN_NUM_DEF      = 4;
    localparam int LED_NUM_DEF      = 8;
    localparam int DEBOUNCE_CYC_DEF = 50000;
    localparam int PWM_WIDTH_DEF    = 4;

    // ceil(log2(cyc)), never below one bit so DEBOUNCE_CYC=2 still has a counter
    function automatic int cnt_width(input int cyc);
        int w;
        w = 1;
        while ((1 << w) < cyc) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - single-channel 2-flop synchroniser followed by a stable-level debouncer
module io_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // acceptance clears the counter, so it never wraps past CNT_MAX
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/board_io_frontend.sv
// rtl/board_io_frontend.sv - debounced switches/buttons with press events and LED drive (BOARD_IO_PWM_EN enables PWM dimming)
module board_io_frontend
    import board_io_pkg::*;
#(
    parameter int SW_NUM       = SW_NUM_DEF,
    parameter int BTN_NUM      = BTN_NUM_DEF,
    parameter int LED_NUM      = LED_NUM_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PWM_WIDTH    = PWM_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [SW_NUM-1:0]    sw_i,
    input  logic [BTN_NUM-1:0]   btn_i,
    output logic [SW_NUM-1:0]    sw_o,
    output logic [BTN_NUM-1:0]   btn_o,
    output logic [BTN_NUM-1:0]   btn_press_o,
    output logic [BTN_NUM-1:0]   btn_evt_o,
    input  logic [BTN_NUM-1:0]   evt_clr_i,
    input  logic [LED_NUM-1:0]   led_i,
    input  logic [PWM_WIDTH-1:0] led_bright_i,
    output logic [LED_NUM-1:0]   led_o
);

    logic [SW_NUM-1:0]  sw_lvl;
    logic [BTN_NUM-1:0] btn_lvl;

    for (genvar g = 0; g < SW_NUM; g++) begin : g_sw
        io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .raw_i    (sw_i[g]),
            .level_o  (sw_lvl[g])
        );
    end

    for (genvar g = 0; g < BTN_NUM; g++) begin : g_btn
        io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .raw_i    (btn_i[g]),
            .level_o  (btn_lvl[g])
        );
    end

    logic [BTN_NUM-1:0] btn_prev_q, btn_prev_d;
    logic [BTN_NUM-1:0] press_q, press_d;
    logic [BTN_NUM-1:0] evt_q, evt_d;

    // press follows the debounced rise by one cycle; set beats clear on collision
    always_comb begin
        btn_prev_d = btn_lvl;
        press_d    = btn_lvl & ~btn_prev_q;
        evt_d      = press_q | (evt_q & ~evt_clr_i);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            btn_prev_q <= '0;
            press_q    <= '0;
            evt_q      <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            evt_q      <= evt_d;
        end
    end

    logic [LED_NUM-1:0] led_q, led_d;

`ifdef BOARD_IO_PWM_EN
    localparam logic [PWM_WIDTH-1:0] BRIGHT_MAX = '1;

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 led_on;

    // full brightness bypasses the comparator so the LED never blinks off
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        led_on    = (led_bright_i == BRIGHT_MAX) || (pwm_cnt_q < led_bright_i);
        led_d     = led_on ? led_i : '0;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    logic unused_bright;

    assign unused_bright = ^led_bright_i;

    always_comb begin
        led_d = led_i;
    end
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign sw_o        = sw_lvl;
    assign btn_o       = btn_lvl;
    assign btn_press_o = press_q;
    assign btn_evt_o   = evt_q;
    assign led_o       = led_q;

endmodule
